tdm_demux2: RTL and testbench
=============================

Name: tdm_demux2

Overview:
- Receive-side counterpart of the 2:1 selector path: deserialises a two-channel time-division-multiplexed bit stream back into parallel channel A and channel B words.
- A transmitter toggles its select line between A and B to build each frame. This block recovers frame alignment from SYNC and reassembles both words.
- It presents each recovered pair with a one-cycle VALID strobe.
- It sits at the receiving end of the serial link, ahead of the consumer logic for channels A and B.

Parameters:
- WIDTH, 8: bits per channel word, legal range 2..32.
- CNT_W, 5: bit-counter width; must satisfy 2^CNT_W >= WIDTH+1.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RSTbar  input  1  asynchronous, active-low reset.
- Gbar  input  1  active-low enable; 1 = pause, all state held.
- DIN  input  1  serial data, MSB first, channel A word then channel B word.
- SYNC  input  1  high on the cycle carrying the first bit (A MSB) of a frame.
- A_OUT  output  WIDTH  last recovered channel A word.
- B_OUT  output  WIDTH  last recovered channel B word.
- VALID  output  1  one-cycle strobe: A_OUT/B_OUT updated this cycle.
- FRAME_ERR  output  1  one-cycle strobe: frame framing violation.
- PAR_ERR  output  1  one-cycle strobe with VALID on parity mismatch (see Optional Feature).

Behaviour:
- Reset (RSTbar=0, asynchronous):
  - state=HUNT, bit counter=0, shift registers=0.
  - A_OUT=0, B_OUT=0, VALID=0, FRAME_ERR=0, PAR_ERR=0.
- Release from reset is synchronous to CLK. The first active edge after release behaves as HUNT.
- A bit is "accepted" on a rising edge with Gbar=0. With Gbar=1:
  - no bit is accepted;
  - state, counter, shift registers and A_OUT/B_OUT hold;
  - VALID, FRAME_ERR and PAR_ERR are driven 0.
- States: HUNT, CH_A, CH_B (plus PAR_A, PAR_B when the optional feature is on).
- HUNT:
  - SYNC=0 bits are discarded.
  - An accepted bit with SYNC=1 is shifted in as A MSB, counter=1, next=CH_A.
- CH_A:
  - Shift DIN into the A shift register on each accepted bit and increment the counter.
  - When the counter reaches WIDTH, go to CH_B with counter=0.
- CH_B:
  - Same as CH_A, into the B shift register.
  - On the edge accepting the WIDTH-th B bit: A_OUT<=A shift, B_OUT<=B_SR with that bit included, VALID<=1 for exactly that following cycle.
  - The same edge sets next=CH_A-expect: the next accepted bit must carry SYNC=1.
- Back-to-back frames:
  - If the bit after the last B bit has SYNC=1, it starts a new frame with no gap; VALID pulses every 2*WIDTH accepted bits.
  - If that bit has SYNC=0: FRAME_ERR=1 for one cycle, bit discarded, state=HUNT.
- SYNC=1 mid-frame (CH_A counter>=1 or any CH_B bit):
  - FRAME_ERR=1 for one cycle.
  - The partial frame is discarded; A_OUT/B_OUT are unchanged.
  - The SYNC bit is taken as A MSB of a new frame (resync, no return to HUNT).
- Latency: last B bit accepted at edge N leads to A_OUT/B_OUT/VALID visible after edge N.
- VALID and FRAME_ERR are never asserted on the same cycle.
- A_OUT/B_OUT change only on cycles with VALID=1.

Optional Feature:
- Macro: TDM_DEMUX2_PARITY_EN.
- Defined:
  - Each channel word is followed by one even-parity bit: frame = A[WIDTH], PA, B[WIDTH], PB, i.e. 2*WIDTH+2 bits.
  - PAR_A and PAR_B each accept one bit and compare it against the XOR of the received word.
  - VALID timing moves to the edge accepting PB.
  - PAR_ERR=1 with VALID if either parity mismatches. Data is still delivered.
  - SYNC=1 during PAR_A/PAR_B is treated as a mid-frame resync.
- Not defined:
  - Frame is 2*WIDTH bits, no PAR states.
  - PAR_ERR port remains present, tied to 0.

Test Plan:
- Reset then frame (WIDTH=8):
  - Stimulus: RSTbar low 3 cycles; after release send SYNC with A=8'hA5, B=8'h3C, Gbar=0.
  - Response: A_OUT=0/B_OUT=0 during reset; VALID 1 cycle after the 16th bit; A_OUT=8'hA5, B_OUT=8'h3C.
- Back-to-back:
  - Stimulus: frames (8'h01,8'h80) then (8'hFF,8'h00) with no gap.
  - Response: two VALID pulses 16 cycles apart, matching words, FRAME_ERR=0.
- Gbar pause:
  - Stimulus: Gbar=1 for 5 cycles after the 4th A bit of (8'h5A,8'hC3).
  - Response: VALID appears 5 cycles later than nominal; A_OUT=8'h5A, B_OUT=8'hC3; no VALID or FRAME_ERR during the pause.
- Resync mid-frame:
  - Stimulus: SYNC=1 on the 3rd B bit, then a full frame (8'h11,8'h22).
  - Response: FRAME_ERR 1 cycle; prior A_OUT/B_OUT held; then VALID with 8'h11/8'h22.
- Missing sync:
  - Stimulus: after a complete frame, the next bit has SYNC=0.
  - Response: FRAME_ERR 1 cycle, state HUNT.
  - Stimulus: a later SYNC frame (8'h77,8'h88).
  - Response: VALID with 8'h77/8'h88.
- Parity (TDM_DEMUX2_PARITY_EN):
  - Stimulus: A=8'h03 with PA=1 (wrong), B=8'h01 with PB=1.
  - Response: VALID with PAR_ERR=1 and A_OUT=8'h03; with correct parity PAR_ERR=0.

Source files
------------

// File: rtl/tdm_demux2.sv
// Two-channel TDM serial-to-parallel receiver with SYNC framing recovery.
// Define TDM_DEMUX2_PARITY_EN to add a per-word even-parity bit and check.
module tdm_demux2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RSTbar,
    input  logic             Gbar,
    input  logic             DIN,
    input  logic             SYNC,
    output logic [WIDTH-1:0] A_OUT,
    output logic [WIDTH-1:0] B_OUT,
    output logic             VALID,
    output logic             FRAME_ERR,
    output logic             PAR_ERR
);

    typedef enum logic [2:0] {
        HUNT,
        CH_A,
        CH_B
`ifdef TDM_DEMUX2_PARITY_EN
        ,
        PAR_A,
        PAR_B
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] b_out_q, b_out_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
`ifdef TDM_DEMUX2_PARITY_EN
    logic             pa_err_q, pa_err_d;
`endif

    logic [WIDTH-1:0] a_next, b_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;
    logic             start;

    assign a_next  = {a_sr_q[WIDTH-2:0], DIN};
    assign b_next  = {b_sr_q[WIDTH-2:0], DIN};
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign last    = (cnt_inc == CNT_W'(WIDTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        start   = 1'b0;
`ifdef TDM_DEMUX2_PARITY_EN
        pa_err_d = pa_err_q;
`endif
        if (!Gbar) begin
            unique case (state_q)
                HUNT: begin
                    start = SYNC;
                end
                CH_A: begin
                    // cnt_q==0 here means a frame just ended and SYNC is due
                    if (cnt_q == '0) begin
                        if (SYNC) begin
                            start = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = HUNT;
                        end
                    end else if (SYNC) begin
                        ferr_d = 1'b1;
                        start  = 1'b1;
                    end else begin
                        a_sr_d = a_next;
                        cnt_d  = cnt_inc;
                        if (last) begin
                            cnt_d = '0;
`ifdef TDM_DEMUX2_PARITY_EN
                            state_d = PAR_A;
`else
                            state_d = CH_B;
`endif
                        end
                    end
                end
                CH_B: begin
                    if (SYNC) begin
                        ferr_d = 1'b1;
                        start  = 1'b1;
                    end else begin
                        b_sr_d = b_next;
                        cnt_d  = cnt_inc;
                        if (last) begin
                            cnt_d = '0;
`ifdef TDM_DEMUX2_PARITY_EN
                            state_d = PAR_B;
`else
                            state_d = CH_A;
                            a_out_d = a_sr_q;
                            b_out_d = b_next;
                            valid_d = 1'b1;
`endif
                        end
                    end
                end
`ifdef TDM_DEMUX2_PARITY_EN
                PAR_A: begin
                    if (SYNC) begin
                        ferr_d = 1'b1;
                        start  = 1'b1;
                    end else begin
                        pa_err_d = DIN ^ (^a_sr_q);
                        state_d  = CH_B;
                        cnt_d    = '0;
                    end
                end
                PAR_B: begin
                    if (SYNC) begin
                        ferr_d = 1'b1;
                        start  = 1'b1;
                    end else begin
                        state_d = CH_A;
                        cnt_d   = '0;
                        a_out_d = a_sr_q;
                        b_out_d = b_sr_q;
                        valid_d = 1'b1;
                        perr_d  = pa_err_q | (DIN ^ (^b_sr_q));
                    end
                end
`endif
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
            if (start) begin
                a_sr_d  = {{(WIDTH-1){1'b0}}, DIN};
                cnt_d   = CNT_W'(1);
                state_d = CH_A;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

`ifdef TDM_DEMUX2_PARITY_EN
    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            pa_err_q <= 1'b0;
        end else begin
            pa_err_q <= pa_err_d;
        end
    end
`endif

    assign A_OUT     = a_out_q;
    assign B_OUT     = b_out_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign PAR_ERR   = perr_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2: framing, pause, resync and parity cases.
// Build with TDM_DEMUX2_PARITY_EN defined to exercise the parity path.
module tb_tdm_demux2;

    localparam int W = 8;
`ifdef TDM_DEMUX2_PARITY_EN
    localparam int FL = 2 * W + 2;
    localparam int NPAR_EXP = 1;
`else
    localparam int FL = 2 * W;
    localparam int NPAR_EXP = 0;
`endif

    logic         CLK = 1'b0;
    logic         RSTbar;
    logic         Gbar;
    logic         DIN;
    logic         SYNC;
    logic [W-1:0] A_OUT;
    logic [W-1:0] B_OUT;
    logic         VALID;
    logic         FRAME_ERR;
    logic         PAR_ERR;

    tdm_demux2 #(.WIDTH(W), .CNT_W(5)) dut (
        .CLK(CLK),
        .RSTbar(RSTbar),
        .Gbar(Gbar),
        .DIN(DIN),
        .SYNC(SYNC),
        .A_OUT(A_OUT),
        .B_OUT(B_OUT),
        .VALID(VALID),
        .FRAME_ERR(FRAME_ERR),
        .PAR_ERR(PAR_ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nvalid, nferr, nboth, npar, nchg, npause;
    int vcyc, vcyc_prev;
    logic [W-1:0] fa, fb, pa_q, pb_q;
    logic last_perr;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        nvalid = 0;
        nferr  = 0;
    endtask

    task automatic step(input logic d, input logic s, input logic g);
        DIN  = d;
        SYNC = s;
        Gbar = g;
        @(posedge CLK);
        #1;
        cyc++;
        if (VALID) begin
            nvalid++;
            vcyc_prev = vcyc;
            vcyc = cyc;
            last_perr = PAR_ERR;
        end
        if (FRAME_ERR) begin
            nferr++;
            fa = A_OUT;
            fb = B_OUT;
        end
        if (VALID && FRAME_ERR) nboth++;
        if (PAR_ERR) npar++;
        if (g && (VALID || FRAME_ERR)) npause++;
        if (!VALID && (A_OUT !== pa_q || B_OUT !== pb_q)) nchg++;
        pa_q = A_OUT;
        pb_q = B_OUT;
    endtask

    task automatic send_fr(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic pa, input logic pb, input int np);
        for (int i = W - 1; i >= 0; i--) begin
            step(a[i], i == W - 1, 1'b0);
            if (i == W - 4) begin
                for (int k = 0; k < np; k++) step(1'b1, 1'b1, 1'b1);
            end
        end
`ifdef TDM_DEMUX2_PARITY_EN
        step(pa, 1'b0, 1'b0);
`endif
        for (int i = W - 1; i >= 0; i--) step(b[i], 1'b0, 1'b0);
`ifdef TDM_DEMUX2_PARITY_EN
        step(pb, 1'b0, 1'b0);
`endif
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        send_fr(a, b, ^a, ^b, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] w;
        int c0;
        nboth = 0; npar = 0; nchg = 0; npause = 0;
        vcyc = 0; vcyc_prev = 0; fa = '0; fb = '0;
        pa_q = '0; pb_q = '0; last_perr = 1'b0;
        RSTbar = 1'b0; Gbar = 1'b0; DIN = 1'b1; SYNC = 1'b1;
        #1;
        check("rst_a", A_OUT, 0);
        check("rst_b", B_OUT, 0);
        check("rst_valid", VALID, 0);
        check("rst_ferr", FRAME_ERR, 0);
        repeat (3) @(posedge CLK);
        #1;
        check("rst_hold_a", A_OUT, 0);
        RSTbar = 1'b1;

        clr();
        c0 = cyc;
        send_frame(8'hA5, 8'h3C);
        check("f1_valid", VALID, 1);
        check("f1_lat", vcyc - c0, FL);
        check("f1_a", A_OUT, 8'hA5);
        check("f1_b", B_OUT, 8'h3C);
        check("f1_nvalid", nvalid, 1);

        clr();
        send_frame(8'h01, 8'h80);
        check("b2b1_a", A_OUT, 8'h01);
        check("b2b1_b", B_OUT, 8'h80);
        send_frame(8'hFF, 8'h00);
        check("b2b2_a", A_OUT, 8'hFF);
        check("b2b2_b", B_OUT, 8'h00);
        check("b2b_nvalid", nvalid, 2);
        check("b2b_gap", vcyc - vcyc_prev, FL);
        check("b2b_ferr", nferr, 0);

        clr();
        c0 = cyc;
        send_fr(8'h5A, 8'hC3, ^8'h5A, ^8'hC3, 5);
        check("pause_lat", vcyc - c0, FL + 5);
        check("pause_a", A_OUT, 8'h5A);
        check("pause_b", B_OUT, 8'hC3);
        check("pause_nvalid", nvalid, 1);
        check("pause_strobe", npause, 0);

        clr();
        w = 8'h99;
        for (int i = W - 1; i >= 0; i--) step(w[i], i == W - 1, 1'b0);
`ifdef TDM_DEMUX2_PARITY_EN
        step(^w, 1'b0, 1'b0);
`endif
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("rs_novalid", nvalid, 0);
        send_frame(8'h11, 8'h22);
        check("rs_ferr", nferr, 1);
        check("rs_held_a", fa, 8'h5A);
        check("rs_held_b", fb, 8'hC3);
        check("rs_a", A_OUT, 8'h11);
        check("rs_b", B_OUT, 8'h22);
        check("rs_nvalid", nvalid, 1);

        clr();
        step(1'b1, 1'b0, 1'b0);
        check("ms_ferr_now", FRAME_ERR, 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("ms_ferr_once", nferr, 1);
        send_frame(8'h77, 8'h88);
        check("ms_a", A_OUT, 8'h77);
        check("ms_b", B_OUT, 8'h88);
        check("ms_nvalid", nvalid, 1);
        check("ms_ferr_tot", nferr, 1);

        clr();
        send_fr(8'h03, 8'h01, 1'b1, 1'b1, 0);
        check("par_valid", nvalid, 1);
        check("par_a", A_OUT, 8'h03);
        check("par_b", B_OUT, 8'h01);
        check("par_err_bad", last_perr, NPAR_EXP);
        send_fr(8'h03, 8'h01, 1'b0, 1'b1, 0);
        check("par_err_good", last_perr, 0);
        check("par_cnt", npar, NPAR_EXP);

        check("valid_ferr_excl", nboth, 0);
        check("out_change_only_valid", nchg, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
